fp_addsub_seq: RTL and testbench
================================

# fp_addsub_seq

Multi-cycle IEEE-754 single-precision adder/subtractor for the Mini-MIPS FPU datapath. It sits directly downstream of the integer-to-float converter and consumes its 32-bit float words as operands for add.s and sub.s. It uses a start/done handshake and an iterative align/normalize datapath, which trades latency for area. Denormals are flushed to zero; NaN and infinity are handled as special cases.

## Interface
Parameters:
- MAX_ALIGN, default 27: cap on alignment shift cycles. Any larger exponent difference is treated as 27.

Ports (one clock; reset is synchronous and active-low):
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: request. Sampled only in IDLE.
- sub, input, 1: operation select. 1 computes a − b; 0 computes a + b. Captured with start.
- a, input, 32: operand A, IEEE-754 single. Captured with start.
- b, input, 32: operand B, IEEE-754 single. Captured with start.
- busy, output, 1: high from the cycle after start is accepted until done falls.
- done, output, 1: one-cycle pulse when result is valid.
- result, output, 32: sum or difference. Held stable from done until the next accepted start.
- overflow, output, 1: result rounded to ±inf from finite operands. Valid with done and held.
- invalid, output, 1: NaN operand or inf − inf. Valid with done and held.

## Operation
Working mantissa is 28 bits: carry, hidden bit, 23 fraction bits, guard, round, sticky.

States and transitions:
- IDLE: waits for start. On start it captures a, b and sub, then goes to UNPACK. Inputs seen while busy is high are ignored.
- UNPACK (1 cycle): classify both operands. Exponent 0 means zero (fraction is discarded). Exponent 255 means inf or NaN. The effective sign of b is b[31]^sub.
  - Special cases go straight to DONE:
    - Any NaN, or inf + (−inf): result 0x7FC00000, invalid=1.
    - Exactly one inf: that inf.
    - Both inputs zero: +0, or −0 only if both effective signs are negative.
    - Exactly one zero: the other operand, with its effective sign.
  - Otherwise: swap so the larger magnitude is the first operand, set d = min(|ea−eb|, MAX_ALIGN), and go to ALIGN.
- ALIGN (d cycles, 0 allowed): shift the smaller mantissa right 1 bit per cycle. Shifted-out bits OR into sticky.
- ADD (1 cycle): add if effective signs match, otherwise subtract the smaller from the larger. The result sign is the larger operand's sign.
  - An exact zero result goes to DONE as +0.
  - Otherwise go to NORM.
- NORM (k cycles, 0 allowed):
  - If carry is set: one right shift with exponent+1, so k=1.
  - Otherwise: shift left 1 bit per cycle, exponent−1 each time, until the hidden bit is set.
- ROUND (1 cycle): apply rounding (see Configuration) and handle range limits.
  - A mantissa carry from rounding increments the exponent.
  - Exponent ≥ 255 gives ±inf with overflow=1.
  - Exponent ≤ 0 gives signed zero (flush).
- DONE (1 cycle): done=1, write result and flags, return to IDLE.

## Timing
- Reset values: result=0, busy=0, done=0, overflow=0, invalid=0. State is IDLE.
- Latency is counted from the start sampling edge to the cycle done is high:
  - Normal path: L = 4 + d + k.
  - Special-case path: L = 2.
  - Exact-cancel path: L = 3.
- busy rises the cycle after the start edge and falls together with done.
- start is accepted again in the cycle after done (IDLE). There is no back-to-back overlap.
- rst_n low at any point aborts the operation: no done pulse, outputs return to reset values at the next edge.

## Configuration
- FPADD_RNE_EN defined: round-to-nearest-even, using guard, round and sticky bits.
- FPADD_RNE_EN undefined: truncation (round toward zero). Guard, round and sticky are dropped.
- Cycle count is identical in both builds.

## Structure
- Package fp_pkg holds:
  - Field widths: EXP_W=8, FRAC_W=23.
  - EXP_BIAS=127, EXP_MAX=255.
  - QNAN=32'h7FC00000.
  - The state enum.
  - The operand-class enum: ZERO, NORM, INF, NAN.
- Sub-module fp_unpack: combinational classification and field split. It is reusable by later FPU stages.

## Test plan
- 0x3F800000 + 0x40000000 (1+2) -> 0x40400000; d=1, k=0, done at L=5.
- 0x42F80000 + 0x40C00000 (124+6) -> 0x43020000; d=4, k=1, L=9.
- 0x40A00000 − 0x40A00000 (sub=1) -> 0x00000000, L=3. Then 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1, L=2.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, L=5.
- 0x3F800000 + 0x33C00000, d=24, L=28:
  - With FPADD_RNE_EN: 0x3F800001.
  - Without FPADD_RNE_EN: 0x3F800000.
- Start re-pulsed while busy with different operands -> ignored, first result unchanged. rst_n low mid-ALIGN -> no done, all outputs 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision field constants, FSM states and operand classes for the Mini-MIPS FPU.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an IEEE-754 single into sign/exponent/mantissa plus class.
// Denormals are classified as zero and their fraction is discarded.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]      x,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [FRAC_W:0]  mant,
  output fp_class_e        cls
);

  always_comb begin
    sign = x[31];
    exp  = x[30:23];
    mant = {1'b1, x[FRAC_W-1:0]};
    cls  = NORM;
    if (x[30:23] == '0) begin
      cls  = ZERO;
      mant = '0;
    end else if (x[30:23] == '1) begin
      cls = (x[FRAC_W-1:0] == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Iterative single-precision add/sub with start/done handshake and flush-to-zero.
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int MAX_ALIGN = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        invalid
);

`ifdef FPADD_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  // m holds hidden, 23 fraction, guard, round, sticky; returns carry + 24-bit mantissa
  function automatic logic [24:0] round_mant(input logic [26:0] m);
    logic up;
    up = RNE_EN & m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[26:3]} + 25'(up);
  endfunction

  state_e state;

  logic [31:0] a_q, b_q;
  logic        sub_q;

  logic             sa, sb_raw, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [FRAC_W:0]  ma, mb;
  fp_class_e        ca, cb;

  fp_unpack u_unpack_a (.x(a_q), .sign(sa),     .exp(ea), .mant(ma), .cls(ca));
  fp_unpack u_unpack_b (.x(b_q), .sign(sb_raw), .exp(eb), .mant(mb), .cls(cb));

  assign sb = sb_raw ^ sub_q;

  logic [27:0]       mx, my;
  logic signed [9:0] ex;
  logic              sx, sy;
  logic [4:0]        cnt;

  logic       a_big;
  logic [7:0] ediff;
  logic [4:0] d_cap;

  assign a_big = {ea, ma} >= {eb, mb};
  assign ediff = a_big ? (ea - eb) : (eb - ea);
  assign d_cap = (ediff > 8'(MAX_ALIGN)) ? 5'(MAX_ALIGN) : ediff[4:0];

  logic        spec_hit, spec_inv;
  logic [31:0] spec_res;

  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    if (ca == NAN || cb == NAN) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (ca == INF && cb == INF) begin
      if (sa != sb) begin
        spec_res = QNAN;
        spec_inv = 1'b1;
      end else begin
        spec_res = {sa, 8'hFF, 23'd0};
      end
    end else if (ca == INF) begin
      spec_res = {sa, 8'hFF, 23'd0};
    end else if (cb == INF) begin
      spec_res = {sb, 8'hFF, 23'd0};
    end else if (ca == ZERO && cb == ZERO) begin
      spec_res = {sa & sb, 31'd0};
    end else if (ca == ZERO) begin
      spec_res = {sb, b_q[30:0]};
    end else if (cb == ZERO) begin
      spec_res = a_q;
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [27:0] sum;
  assign sum = (sx == sy) ? (mx + my) : (mx - my);

  logic [24:0]       rm;
  logic signed [9:0] ex_r;
  logic [31:0]       rnd_res;
  logic              rnd_ovf;

  always_comb begin
    rm      = round_mant(mx[26:0]);
    ex_r    = rm[24] ? (ex + 10'sd1) : ex;
    rnd_ovf = 1'b0;
    if (ex_r >= 10'(EXP_MAX)) begin
      rnd_res = {sx, 8'hFF, 23'd0};
      rnd_ovf = 1'b1;
    end else if (ex_r <= 10'sd0) begin
      rnd_res = {sx, 31'd0};
    end else begin
      rnd_res = {sx, ex_r[7:0], rm[24] ? rm[23:1] : rm[22:0]};
    end
  end

  // Datapath registers: loaded by state, no reset needed
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (start) begin
        a_q   <= a;
        b_q   <= b;
        sub_q <= sub;
      end
      S_UNPACK: begin
        mx  <= a_big ? {1'b0, ma, 3'b000} : {1'b0, mb, 3'b000};
        my  <= a_big ? {1'b0, mb, 3'b000} : {1'b0, ma, 3'b000};
        ex  <= signed'({2'b00, a_big ? ea : eb});
        sx  <= a_big ? sa : sb;
        sy  <= a_big ? sb : sa;
        cnt <= d_cap;
      end
      S_ALIGN: begin
        my  <= {1'b0, my[27:2], my[1] | my[0]};
        cnt <= cnt - 5'd1;
      end
      S_ADD: mx <= sum;
      S_NORM: begin
        if (mx[27]) begin
          mx <= {1'b0, mx[27:2], mx[1] | mx[0]};
          ex <= ex + 10'sd1;
        end else begin
          mx <= {mx[26:0], 1'b0};
          ex <= ex - 10'sd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_UNPACK;
            busy  <= 1'b1;
          end
        end
        S_UNPACK: begin
          if (spec_hit) begin
            state    <= S_DONE;
            done     <= 1'b1;
            result   <= spec_res;
            invalid  <= spec_inv;
            overflow <= 1'b0;
          end else begin
            state <= (d_cap == 5'd0) ? S_ADD : S_ALIGN;
          end
        end
        S_ALIGN: if (cnt <= 5'd1) state <= S_ADD;
        S_ADD: begin
          if (sum == '0) begin
            state    <= S_DONE;
            done     <= 1'b1;
            result   <= '0;
            invalid  <= 1'b0;
            overflow <= 1'b0;
          end else if (sum[27] || !sum[26]) begin
            state <= S_NORM;
          end else begin
            state <= S_ROUND;
          end
        end
        // Carry needs one right shift; otherwise stop once bit 25 moves into the hidden slot
        S_NORM: if (mx[27] || mx[25]) state <= S_ROUND;
        S_ROUND: begin
          state    <= S_DONE;
          done     <= 1'b1;
          result   <= rnd_res;
          overflow <= rnd_ovf;
          invalid  <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: hand-computed results, flags and latencies.
module tb_fp_addsub_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        invalid;

  int checks   = 0;
  int failures = 0;

  fp_addsub_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .sub(sub),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .overflow(overflow),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic [31:0] exp_res, input logic exp_ovf,
                        input logic exp_inv, input int exp_lat, input logic repulse);
    int   n;
    logic seen;
    @(negedge clk);
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    seen = done;
    while (!seen && n < 100) begin
      if (repulse && n == 2) begin
        a     = 32'h40A00000;
        b     = 32'h41200000;
        sub   = 1'b1;
        start = 1'b1;
      end else if (repulse && n == 3) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      seen = done;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_inv"}, 32'(invalid), 32'(exp_inv));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  logic [31:0] exp_tiny;
  logic        seen_abort;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
`ifdef FPADD_RNE_EN
    exp_tiny = 32'h3F800001;
`else
    exp_tiny = 32'h3F800000;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_inv", 32'(invalid), 32'd0);
    rst_n = 1'b1;

    run_op("one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 5, 1'b0);
    run_op("carry_norm",    32'h42F80000, 32'h40C00000, 1'b0, 32'h43020000, 1'b0, 1'b0, 9, 1'b0);
    run_op("exact_cancel",  32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000, 1'b0, 1'b0, 3, 1'b0);
    run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1, 2, 1'b0);
    run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 5, 1'b0);
    run_op("left_norm",     32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 1'b0, 1'b0, 6, 1'b0);
    run_op("zero_minus_b",  32'h00000000, 32'h40200000, 1'b1, 32'hC0200000, 1'b0, 1'b0, 2, 1'b0);
    run_op("neg_zeros",     32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 2, 1'b0);
    run_op("inf_minus_one", 32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 1'b0, 1'b0, 2, 1'b0);
    run_op("nan_operand",   32'h3F800000, 32'h7FC00001, 1'b0, 32'h7FC00000, 1'b0, 1'b1, 2, 1'b0);
    run_op("tiny_round",    32'h3F800000, 32'h33C00000, 1'b0, exp_tiny,     1'b0, 1'b0, 28, 1'b0);
    run_op("repulse",       32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 5, 1'b1);

    // Abort a long alignment with reset partway through
    @(negedge clk);
    a     = 32'h3F800000;
    b     = 32'h33C00000;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_inv", 32'(invalid), 32'd0);
    rst_n      = 1'b1;
    seen_abort = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) seen_abort = 1'b1;
    end
    check("abort_no_done", 32'(seen_abort), 32'd0);

    run_op("after_abort",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
